floor_request_debouncer: RTL and testbench

//  Front end of the elevator request path. Debounces raw floor-call buttons using the

---
 rtl/elevator_pkg.sv | 24 ++
 rtl/debounce_cell.sv | 55 +++++
 rtl/floor_request_debouncer.sv | 141 ++++++++++++++
 tb/tb_floor_request_debouncer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared constants, offer FSM state type and helpers for the
//               elevator request front end.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int unsigned N_FLOORS_DEFAULT = 8;
    localparam int unsigned FLOOR_W          = $clog2(N_FLOORS_DEFAULT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } offer_state_t;

    // Debounce counter width; a single-sample debounce still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned samples);
        return (samples > 1) ? $clog2(samples) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : One floor button: 2-flop synchronizer, strobe-driven debounce
//               counter, stable level and one-cycle press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press
);

    localparam int unsigned          c_cnt_w    = cnt_width(DEBOUNCE_SAMPLES);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(DEBOUNCE_SAMPLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;
    logic               r_stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], btn_raw};
            r_stable_d <= r_stable;
            if (strobe) begin
                if (r_sync[1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign btn_stable = r_stable;
    assign press      = r_stable & ~r_stable_d;

endmodule
`default_nettype wire

// File: rtl/floor_request_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : floor_request_debouncer
// Description : Debounces floor-call buttons on the divider strobe, tracks
//               pending requests and offers them lowest-floor-first over
//               valid/ready. FLOOR_REQ_DROP_CNT_EN builds the duplicate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_request_debouncer
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS         = N_FLOORS_DEFAULT,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    input  logic [N_FLOORS-1:0]         btn_raw,
    output logic [N_FLOORS-1:0]         btn_stable,
    output logic                        req_valid,
    output logic [$clog2(N_FLOORS)-1:0] req_floor,
    input  logic                        req_ready,
    output logic [7:0]                  dropped_cnt
);

    localparam int unsigned c_floor_w = $clog2(N_FLOORS);

    logic                  r_tick_d;
    logic                  w_strobe;
    logic [N_FLOORS-1:0]   w_press;
    logic [N_FLOORS-1:0]   r_pending;
    logic [N_FLOORS-1:0]   w_pending_nxt;
    logic [N_FLOORS-1:0]   w_offered;
    logic [N_FLOORS-1:0]   w_load_mask;
    logic [N_FLOORS-1:0]   w_dup;
    logic [c_floor_w-1:0]  w_low_idx;
    logic [c_floor_w-1:0]  r_req_floor;
    logic [c_floor_w-1:0]  w_req_floor_nxt;
    offer_state_t          r_state;
    offer_state_t          w_state_nxt;
    logic                  w_any_pending;
    logic                  w_accept;
    logic                  w_load;

    always_ff @(posedge clk) begin
        if (rst) r_tick_d <= 1'b0;
        else     r_tick_d <= tick_in;
    end

    assign w_strobe = tick_in & ~r_tick_d;

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor
        debounce_cell #(
            .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .strobe    (w_strobe),
            .btn_raw   (btn_raw[gi]),
            .btn_stable(btn_stable[gi]),
            .press     (w_press[gi])
        );
    end

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i]) w_low_idx = c_floor_w'(i);
        end
    end

    assign w_any_pending = |r_pending;
    assign w_accept      = req_valid & req_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_floor_nxt = r_req_floor;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (w_accept) begin
                    if (w_any_pending) w_load      = 1'b1;
                    else               w_state_nxt = ST_IDLE;
                end
            end
        endcase
        if (w_load) w_req_floor_nxt = w_low_idx;
    end

    // A press on a floor already pending or on the wire is a duplicate; the
    // floor being loaded this cycle is still pending, so it is covered too.
    always_comb begin
        w_offered   = '0;
        w_load_mask = '0;
        if (req_valid) w_offered[r_req_floor] = 1'b1;
        if (w_load)    w_load_mask[w_low_idx] = 1'b1;
    end

    assign w_dup         = w_press & (r_pending | w_offered);
    assign w_pending_nxt = (r_pending & ~w_load_mask) | (w_press & ~w_dup);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_floor <= '0;
            r_pending   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_floor <= w_req_floor_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    assign req_valid = (r_state == ST_OFFER);
    assign req_floor = r_req_floor;

`ifdef FLOOR_REQ_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if ((|w_dup) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign dropped_cnt = r_drop_cnt;
`else
    assign dropped_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_floor_request_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_request_debouncer
// Description : Directed scenarios plus random button/ready traffic, checked
//               every cycle against a behavioural model of the request path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_request_debouncer;

    localparam int N  = 8;
    localparam int DS = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         tick_in   = 1'b0;
    logic         req_ready = 1'b0;
    logic [N-1:0] btn_raw   = '0;
    logic [N-1:0] btn_stable;
    logic         req_valid;
    logic [2:0]   req_floor;
    logic [7:0]   dropped_cnt;

    int n_vec = 0;
    int n_err = 0;

    floor_request_debouncer #(
        .N_FLOORS        (N),
        .DEBOUNCE_SAMPLES(DS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .btn_raw    (btn_raw),
        .btn_stable (btn_stable),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .req_ready  (req_ready),
        .dropped_cnt(dropped_cnt)
    );

    initial forever #5 clk = ~clk;

    // Divider output: toggles every 16 clk, so one strobe per 32 clk.
    initial forever begin
        repeat (16) @(posedge clk);
        #1 tick_in = ~tick_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_sync1[N], m_sync2[N], m_stable[N], m_rose[N], m_pend[N];
    int m_run[N];
    bit m_tick_d, m_valid;
    int m_floor, m_drops;

    task automatic model_step();
        bit fresh[N];
        bit any_dup;
        bit strobe;
        int low;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_sync1[i] = 0; m_sync2[i] = 0; m_stable[i] = 0;
                m_rose[i] = 0; m_pend[i] = 0; m_run[i] = 0;
            end
            m_tick_d = 0; m_valid = 0; m_floor = 0; m_drops = 0;
            return;
        end
        strobe  = tick_in && !m_tick_d;
        any_dup = 0;
        for (int i = 0; i < N; i++) begin
            fresh[i] = m_rose[i];
            if (fresh[i] && (m_pend[i] || (m_valid && m_floor == i))) begin
                fresh[i] = 0;
                any_dup  = 1;
            end
        end
        if (!m_valid || req_ready) begin
            low = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && low < 0) low = i;
            if (low >= 0) begin
                m_valid = 1; m_floor = low; m_pend[low] = 0;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N; i++) if (fresh[i]) m_pend[i] = 1;
        if (any_dup && m_drops < 255) m_drops++;
        // A level change is accepted once DS consecutive strobes disagree.
        for (int i = 0; i < N; i++) begin
            m_rose[i] = 0;
            if (strobe) begin
                m_run[i] = (m_sync2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DS) begin
                    m_stable[i] = m_sync2[i];
                    m_run[i]    = 0;
                    m_rose[i]   = m_stable[i];
                end
            end
            m_sync2[i] = m_sync1[i];
            m_sync1[i] = btn_raw[i];
        end
        m_tick_d = tick_in;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle checker and monitors ----------------
    bit   chk_en     = 0;
    int   strobe_cnt = 0;
    logic tick_seen  = 1'b0;
    int   acc_q[$];

    initial forever begin
        logic [N-1:0] exp_st;
        int           exp_drop;
        @(negedge clk);
        if (tick_in && !tick_seen) strobe_cnt++;
        tick_seen = tick_in;
        if (req_valid === 1'b1 && req_ready) acc_q.push_back(int'(req_floor));
        if (chk_en) begin
            for (int i = 0; i < N; i++) exp_st[i] = m_stable[i];
`ifdef FLOOR_REQ_DROP_CNT_EN
            exp_drop = m_drops;
`else
            exp_drop = 0;
`endif
            check("model_stable", 32'(btn_stable), 32'(exp_st));
            check("model_valid", 32'(req_valid), 32'(m_valid));
            check("model_floor", 32'(req_floor), 32'(m_floor));
            check("model_dropped", 32'(dropped_cnt), 32'(exp_drop));
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_strobe();
        int s = strobe_cnt;
        int k = 0;
        while (strobe_cnt == s && k < 64) begin cyc(); k++; end
        if (strobe_cnt == s) timeout("wait_strobe");
    endtask

    task automatic wait_bit(input int idx, input logic val, input string tag);
        int k = 0;
        while (btn_stable[idx] !== val && k < 400) begin cyc(); k++; end
        if (btn_stable[idx] !== val) timeout(tag);
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_q.size() < n && k < 100) begin cyc(); k++; end
        if (acc_q.size() < n) timeout(tag);
    endtask

    function automatic int count_acc(input int f);
        int c = 0;
        foreach (acc_q[k]) if (acc_q[k] == f) c++;
        return c;
    endfunction

    int drop_exp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  s0;
        int  k;
        bit  ok;
`ifdef FLOOR_REQ_DROP_CNT_EN
        drop_exp = 1;
`else
        drop_exp = 0;
`endif
        // T1: reset with all buttons held
        rst = 1'b1; btn_raw = 8'hFF; req_ready = 1'b0;
        cyc();
        chk_en = 1;
        cyc(2);
        check("t1_rst_stable", 32'(btn_stable), 32'h0);
        check("t1_rst_valid", 32'(req_valid), 32'h0);
        check("t1_rst_floor", 32'(req_floor), 32'h0);
        check("t1_rst_dropped", 32'(dropped_cnt), 32'h0);
        k = 0;
        while (tick_in !== 1'b1 && k < 40) begin cyc(); k++; end
        k = 0;
        while (tick_in !== 1'b0 && k < 40) begin cyc(); k++; end
        rst = 1'b0;
        s0  = strobe_cnt;
        ok  = 1;
        k   = 0;
        while (btn_stable === 8'h00 && k < 400) begin
            cyc();
            if (req_valid !== 1'b0) ok = 0;
            k++;
        end
        check("t1_stable_all", 32'(btn_stable), 32'hFF);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd4);
        check("t1_no_early_valid", 32'(ok), 32'd1);
        cyc();
        check("t1_valid_lat1", 32'(req_valid), 32'h0);
        cyc();
        check("t1_valid_lat2", 32'(req_valid), 32'h1);
        check("t1_floor0", 32'(req_floor), 32'h0);
        acc_q.delete();
        req_ready = 1'b1; btn_raw = 8'h00;
        wait_acc(8, "t1_drain");
        for (int f = 0; f < 8 && f < acc_q.size(); f++) check("t1_order", 32'(acc_q[f]), 32'(f));
        cyc(2);
        req_ready = 1'b0;
        wait_bit(0, 1'b0, "t1_release");
        check("t1_released", 32'(btn_stable), 32'h0);

        // T2: bounce on floor 3
        acc_q.delete();
        wait_strobe(); btn_raw[3] = 1'b1;
        wait_strobe(); btn_raw[3] = 1'b0;
        wait_strobe(); btn_raw[3] = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            wait_strobe();
            check("t2_stable3", 32'(btn_stable[3]), 32'(s == 4));
        end
        cyc();
        check("t2_valid_lat1", 32'(req_valid), 32'h0);
        cyc();
        check("t2_valid", 32'(req_valid), 32'h1);
        check("t2_floor", 32'(req_floor), 32'd3);
        req_ready = 1'b1;
        wait_acc(1, "t2_accept");
        cyc();
        req_ready = 1'b0;
        check("t2_count3", 32'(count_acc(3)), 32'd1);
        btn_raw[3] = 1'b0;
        wait_bit(3, 1'b0, "t2_release");

        // T3: simultaneous floors 5 and 2, held offer then back-to-back
        acc_q.delete();
        wait_strobe();
        btn_raw[5] = 1'b1; btn_raw[2] = 1'b1;
        wait_bit(2, 1'b1, "t3_press");
        check("t3_stable5", 32'(btn_stable[5]), 32'h1);
        cyc(2);
        check("t3_valid", 32'(req_valid), 32'h1);
        check("t3_floor2", 32'(req_floor), 32'd2);
        ok = 1;
        repeat (20) begin
            cyc();
            if (req_valid !== 1'b1 || req_floor !== 3'd2) ok = 0;
        end
        check("t3_hold20", 32'(ok), 32'd1);
        req_ready = 1'b1;
        cyc();
        check("t3_b2b_valid", 32'(req_valid), 32'h1);
        check("t3_b2b_floor5", 32'(req_floor), 32'd5);
        cyc();
        check("t3_idle", 32'(req_valid), 32'h0);
        req_ready = 1'b0;
        check("t3_accepted", 32'(acc_q.size()), 32'd2);

        // T4: re-press floor 2 while it is on offer
        btn_raw = 8'h00;
        wait_bit(2, 1'b0, "t4_release_a");
        acc_q.delete();
        btn_raw[2] = 1'b1;
        wait_bit(2, 1'b1, "t4_press_a");
        cyc(2);
        check("t4_offer2", 32'(req_floor), 32'd2);
        btn_raw[2] = 1'b0;
        wait_bit(2, 1'b0, "t4_release_b");
        btn_raw[2] = 1'b1;
        wait_bit(2, 1'b1, "t4_press_b");
        cyc(2);
        check("t4_dropped", 32'(dropped_cnt), 32'(drop_exp));
        check("t4_still_2", 32'(req_floor), 32'd2);
        req_ready = 1'b1;
        cyc(10);
        req_ready = 1'b0;
        check("t4_single_offer", 32'(count_acc(2)), 32'd1);
        check("t4_idle", 32'(req_valid), 32'h0);
        btn_raw[2] = 1'b0;
        wait_bit(2, 1'b0, "t4_release_c");

        // T5: press then release floor 6
        acc_q.delete();
        req_ready = 1'b1;
        wait_strobe();
        btn_raw[6] = 1'b1;
        repeat (4) wait_strobe();
        check("t5_pressed", 32'(btn_stable[6]), 32'h1);
        btn_raw[6] = 1'b0;
        repeat (4) wait_strobe();
        check("t5_released", 32'(btn_stable[6]), 32'h0);
        cyc(20);
        check("t5_one_offer", 32'(count_acc(6)), 32'd1);
        req_ready = 1'b0;

        // T6: reset while offering with floors 1 and 4 pending
        btn_raw = 8'h13;
        wait_bit(0, 1'b1, "t6_press");
        cyc(2);
        check("t6_offer0", 32'(req_floor), 32'd0);
        check("t6_pending", 32'(dut.r_pending), 32'h12);
        rst = 1'b1; btn_raw = 8'h00;
        cyc();
        check("t6_valid_drop", 32'(req_valid), 32'h0);
        check("t6_pending_clr", 32'(dut.r_pending), 32'h0);
        cyc(2);
        rst = 1'b0;
        ok = 1;
        repeat (200) begin
            cyc();
            if (req_valid !== 1'b0) ok = 0;
        end
        check("t6_no_stale", 32'(ok), 32'd1);

        // Random traffic: bouncy buttons and a random ready, model-checked
        repeat (40) begin
            btn_raw = btn_raw ^ 8'($urandom & $urandom);
            repeat ($urandom_range(1, 150)) begin
                req_ready = 1'($urandom);
                if ($urandom_range(0, 15) == 0) btn_raw[$urandom_range(0, 7)] ^= 1'b1;
                cyc();
            end
        end
        req_ready = 1'b1;
        btn_raw   = 8'h00;
        cyc(400);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
